// File: rtl/load_store_exec_pkg.sv
// Shared processor-unit types: load modes, load/store execute FSM states and
// the big-endian byte-enable patterns used on the data bus.
package Pu_types;

    typedef enum logic [1:0] {
        Load_null     = 2'd0,
        Load_byte     = 2'd1,
        Load_halfword = 2'd2,
        Load_word     = 2'd3
    } Load_mode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } Ls_exec_state;

    // Bit 3 of the enable vector is byte offset 0 (big-endian lane order).
    localparam logic [3:0] Be_byte0 = 4'b1000;
    localparam logic [3:0] Be_byte1 = 4'b0100;
    localparam logic [3:0] Be_byte2 = 4'b0010;
    localparam logic [3:0] Be_byte3 = 4'b0001;
    localparam logic [3:0] Be_half0 = 4'b1100;
    localparam logic [3:0] Be_half2 = 4'b0011;
    localparam logic [3:0] Be_word  = 4'b1111;

    function automatic logic [3:0] be_for(input Load_mode m, input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (m)
            Load_byte: begin
                case (offset)
                    2'd0:    be = Be_byte0;
                    2'd1:    be = Be_byte1;
                    2'd2:    be = Be_byte2;
                    default: be = Be_byte3;
                endcase
            end
            Load_halfword: be = offset[1] ? Be_half2 : Be_half0;
            Load_word:     be = Be_word;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_store_exec_align.sv
// Combinational load-lane extraction: picks the addressed byte/halfword out of
// a big-endian bus word and extends it to 32 bits.
module ls_align
    import Pu_types::*;
(
    input  logic [31:0] rdata,
    input  Load_mode    mode,
    input  logic [1:0]  offset,
    input  logic        exts,
    output logic [31:0] data
);

    logic [15:0] half;

    // Bytes are always zero-extended; only halfwords honour exts.
    always_comb begin
        data = 32'd0;
        half = offset[1] ? rdata[15:0] : rdata[31:16];
        case (mode)
            Load_byte: begin
                case (offset)
                    2'd0:    data = {24'd0, rdata[31:24]};
                    2'd1:    data = {24'd0, rdata[23:16]};
                    2'd2:    data = {24'd0, rdata[15:8]};
                    default: data = {24'd0, rdata[7:0]};
                endcase
            end
            Load_halfword: data = {{16{exts & half[15]}}, half};
            Load_word:     data = rdata;
            default:       data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_exec.sv
// Execute-stage load/store unit: registers the bus request, runs the req/ack
// handshake and hands either load data or the effective address to writeback.
module load_store_exec
    import Pu_types::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_dec,
    input  logic                  we,
    input  Load_mode              mode,
    input  logic                  exts,
    input  logic                  return_dout,
    input  logic                  keep_eff_addr,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           result,
    output logic                  result_valid,
    output logic [ADDR_WIDTH-1:0] eff_addr_q,
    output logic                  align_err
);

    Ls_exec_state          state_q;
    Load_mode              mode_q;
    logic                  exts_q;
    logic                  return_dout_q;
    logic [1:0]            offset_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           load_q;
    logic [31:0]           load_ext;
    logic [31:0]           addr_ext;
    logic [31:0]           wdata_rep;
    logic                  accept;
    logic                  misaligned;

    assign accept     = en_dec && (mode != Load_null) && (state_q == IDLE);
    assign misaligned = ((mode == Load_halfword) && eff_addr[0]) ||
                        ((mode == Load_word) && (eff_addr[1:0] != 2'b00));

    // Store operand replicated across every lane it could land in, so the
    // byte enables alone select what memory writes.
    always_comb begin
        wdata_rep = store_data;
        addr_ext  = 32'd0;
        case (mode)
            Load_byte:     wdata_rep = {4{store_data[7:0]}};
            Load_halfword: wdata_rep = {2{store_data[15:0]}};
            default:       wdata_rep = store_data;
        endcase
        addr_ext[ADDR_WIDTH-1:0] = addr_q;
    end

    ls_align u_align (
        .rdata  (mem_rdata),
        .mode   (mode_q),
        .offset (offset_q),
        .exts   (exts_q),
        .data   (load_ext)
    );

    // Bus outputs are held in registers, so they stay stable for the whole
    // ACCESS state regardless of how long mem_ack takes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            busy          <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'b0000;
            mem_wdata     <= 32'd0;
            result        <= 32'd0;
            result_valid  <= 1'b0;
            align_err     <= 1'b0;
            eff_addr_q    <= '0;
            mode_q        <= Load_null;
            exts_q        <= 1'b0;
            return_dout_q <= 1'b0;
            offset_q      <= 2'd0;
            addr_q        <= '0;
            load_q        <= 32'd0;
        end else begin
            result_valid <= 1'b0;
            align_err    <= 1'b0;
            if (accept && keep_eff_addr) begin
                eff_addr_q <= eff_addr;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            align_err <= 1'b1;
                        end else begin
                            mem_addr      <= {eff_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be        <= be_for(mode, eff_addr[1:0]);
                            mem_wdata     <= wdata_rep;
                            mem_we        <= we;
                            mode_q        <= mode;
                            exts_q        <= exts;
                            return_dout_q <= return_dout;
                            offset_q      <= eff_addr[1:0];
                            addr_q        <= eff_addr;
                            mem_req       <= 1'b1;
                            busy          <= 1'b1;
                            state_q       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            load_q  <= load_ext;
                            state_q <= RESP;
                        end else if (!return_dout_q) begin
                            state_q <= RESP;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                RESP: begin
                    result_valid <= 1'b1;
                    result       <= return_dout_q ? load_q : addr_ext;
                    busy         <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_exec.sv
// Directed self-checking bench for load_store_exec: loads, stores, wait states,
// misalignment, busy-time requests and reset during an access.
module tb_load_store_exec;
    import Pu_types::*;

    logic        clk;
    logic        reset;
    logic        en_dec;
    logic        we;
    Load_mode    mode;
    logic        exts;
    logic        return_dout;
    logic        keep_eff_addr;
    logic [31:0] eff_addr;
    logic [31:0] store_data;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] eff_addr_q;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_exec #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .en_dec        (en_dec),
        .we            (we),
        .mode          (mode),
        .exts          (exts),
        .return_dout   (return_dout),
        .keep_eff_addr (keep_eff_addr),
        .eff_addr      (eff_addr),
        .store_data    (store_data),
        .busy          (busy),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .result        (result),
        .result_valid  (result_valid),
        .eff_addr_q    (eff_addr_q),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one op at a negedge, ack after 'waits' stall cycles, then check
    // the response phase. Called and returns on a negedge.
    task automatic do_op(input string tag, input logic w, input Load_mode m, input logic x,
                         input logic rd, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int waits, input logic [3:0] exp_be,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_result);
        en_dec = 1'b1; we = w; mode = m; exts = x; return_dout = rd;
        keep_eff_addr = 1'b0; eff_addr = addr; store_data = sd;
        @(negedge clk);
        en_dec = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            check({tag, " req"}, {31'd0, mem_req}, 32'd1);
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            check({tag, " we"}, {31'd0, mem_we}, {31'd0, w});
            check({tag, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
            check({tag, " addr"}, mem_addr, exp_addr);
            if (w) check({tag, " wdata"}, mem_wdata, exp_wdata);
            if (i == waits) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
        check({tag, " req drop"}, {31'd0, mem_req}, 32'd0);
        check({tag, " rv early"}, {31'd0, result_valid}, 32'd0);
        if (w && rd) begin
            check({tag, " busy end"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({tag, " no rv"}, {31'd0, result_valid}, 32'd0);
        end else begin
            check({tag, " busy resp"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            check({tag, " rv"}, {31'd0, result_valid}, 32'd1);
            check({tag, " result"}, result, exp_result);
            check({tag, " busy idle"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({tag, " rv pulse"}, {31'd0, result_valid}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; en_dec = 1'b0; we = 1'b0; mode = Load_null; exts = 1'b0;
        return_dout = 1'b0; keep_eff_addr = 1'b0; eff_addr = 32'd0;
        store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #23;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst req", {31'd0, mem_req}, 32'd0);
        check("rst be", {28'd0, mem_be}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst effq", eff_addr_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op("lb", 1'b0, Load_byte, 1'b0, 1'b1, 32'h101, 32'd0, 32'h11223344, 0,
              4'b0100, 32'h100, 32'd0, 32'h00000022);
        do_op("lh sx", 1'b0, Load_halfword, 1'b1, 1'b1, 32'h202, 32'd0, 32'h12348001, 0,
              4'b0011, 32'h200, 32'd0, 32'hFFFF8001);
        do_op("lh zx", 1'b0, Load_halfword, 1'b0, 1'b1, 32'h202, 32'd0, 32'h12348001, 0,
              4'b0011, 32'h200, 32'd0, 32'h00008001);
        do_op("lh0 sx", 1'b0, Load_halfword, 1'b1, 1'b1, 32'h200, 32'd0, 32'h9ABC0001, 1,
              4'b1100, 32'h200, 32'd0, 32'hFFFF9ABC);
        do_op("lb3", 1'b0, Load_byte, 1'b1, 1'b1, 32'h107, 32'd0, 32'h112233F4, 0,
              4'b0001, 32'h104, 32'd0, 32'h000000F4);
        do_op("sb", 1'b1, Load_byte, 1'b0, 1'b1, 32'h303, 32'h000000AB, 32'd0, 0,
              4'b0001, 32'h300, 32'hABABABAB, 32'd0);
        do_op("sh", 1'b1, Load_halfword, 1'b0, 1'b1, 32'h306, 32'h0000CDEF, 32'd0, 0,
              4'b0011, 32'h304, 32'hCDEFCDEF, 32'd0);
        do_op("sw upd", 1'b1, Load_word, 1'b0, 1'b0, 32'h400, 32'hDEADBEEF, 32'd0, 3,
              4'b1111, 32'h400, 32'hDEADBEEF, 32'h00000400);

        // Load_null is not an accept.
        en_dec = 1'b1; mode = Load_null; keep_eff_addr = 1'b1; eff_addr = 32'h777;
        @(negedge clk);
        en_dec = 1'b0;
        check("null req", {31'd0, mem_req}, 32'd0);
        check("null effq", eff_addr_q, 32'd0);

        en_dec = 1'b1; we = 1'b0; mode = Load_word; keep_eff_addr = 1'b1; eff_addr = 32'h502;
        @(negedge clk);
        en_dec = 1'b0;
        check("mis err", {31'd0, align_err}, 32'd1);
        check("mis req", {31'd0, mem_req}, 32'd0);
        check("mis busy", {31'd0, busy}, 32'd0);
        check("mis effq", eff_addr_q, 32'h502);
        @(negedge clk);
        check("mis pulse", {31'd0, align_err}, 32'd0);
        check("mis req2", {31'd0, mem_req}, 32'd0);

        en_dec = 1'b1; mode = Load_halfword; keep_eff_addr = 1'b0; eff_addr = 32'h507;
        @(negedge clk);
        en_dec = 1'b0;
        check("mish err", {31'd0, align_err}, 32'd1);
        check("mish effq", eff_addr_q, 32'h502);
        @(negedge clk);

        // Reset while stalled in ACCESS; a busy-time request must be ignored.
        en_dec = 1'b1; we = 1'b0; mode = Load_word; return_dout = 1'b1;
        keep_eff_addr = 1'b0; eff_addr = 32'h600;
        @(negedge clk);
        en_dec = 1'b1; keep_eff_addr = 1'b1; eff_addr = 32'h704; mode = Load_word;
        @(negedge clk);
        en_dec = 1'b0; keep_eff_addr = 1'b0;
        check("busy ign effq", eff_addr_q, 32'h502);
        check("busy ign addr", mem_addr, 32'h600);
        check("stall req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst mid req", {31'd0, mem_req}, 32'd0);
        check("rst mid busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        check("post rst rv", {31'd0, result_valid}, 32'd0);
        check("post rst req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("post rst rv2", {31'd0, result_valid}, 32'd0);
        check("post rst busy", {31'd0, busy}, 32'd0);

        do_op("lw", 1'b0, Load_word, 1'b0, 1'b1, 32'h600, 32'd0, 32'hCAFEF00D, 1,
              4'b1111, 32'h600, 32'd0, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
